// File: rtl/dsp_router_pkg.sv
// Shared definitions for the DSP router/mixer: bus offsets, select word type and
// the saturation helper used by every mix channel.
package dsp_router_pkg;

  localparam logic [15:0] OFF_INSEL   = 16'h0000;
  localparam logic [15:0] OFF_OUTSEL  = 16'h0004;
  localparam logic [15:0] OFF_STICKY  = 16'h0008;
  localparam logic [15:0] OFF_LIVESAT = 16'h000C;

  // Wide enough for LOG_SRC up to 8 and NOUT up to 8.
  localparam int SEL_W = 8;
  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_res_t;

  function automatic sat_res_t saturate(input logic signed [31:0] sum, input int dw);
    sat_res_t res;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (sum > hi) begin
      res.ovf = 1'b1;
      res.val = hi;
    end else if (sum < lo) begin
      res.ovf = 1'b1;
      res.val = lo;
    end else begin
      res.ovf = 1'b0;
      res.val = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_adder_tree.sv
// One mix channel: gated, sign-extended leaf register, LOG_DIR registered 2-input
// adder levels over a zero-padded heap, then a saturating output register.
module dsp_adder_tree
  import dsp_router_pkg::*;
#(
  parameter int DW      = 14,
  parameter int NDIR    = 10,
  parameter int LOG_DIR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIR*DW-1:0] dir,
  input  logic [NDIR-1:0]    en,
  output logic [DW-1:0]      mix,
  output logic               sat
);

  localparam int LEAVES = 2 ** LOG_DIR;
  localparam int TW     = DW + LOG_DIR;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [LEAVES*DW-1:0] dir_pad;
  logic [LEAVES-1:0]    en_pad;
  logic signed [TW-1:0] node [NODES];
  sat_res_t             res;
  logic                 unused_res;

  always_comb begin
    dir_pad              = '0;
    dir_pad[NDIR*DW-1:0] = dir;
    en_pad               = '0;
    en_pad[NDIR-1:0]     = en;
  end

  assign res        = saturate({{(32-TW){node[0][TW-1]}}, node[0]}, DW);
  assign unused_res = ^res.val[31:DW];

  // Heap layout: leaves at LEAVES-1.., node i sums children 2i+1 and 2i+2,
  // so every level is one register stage and node 0 is the full sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) node[i] <= '0;
      mix <= '0;
      sat <= 1'b0;
    end else begin
      for (int k = 0; k < LEAVES; k++) begin
        node[LEAVES-1+k] <= en_pad[k] ? {{LOG_DIR{dir_pad[k*DW+DW-1]}}, dir_pad[k*DW +: DW]}
                                      : '0;
      end
      for (int i = 0; i < LEAVES - 1; i++) node[i] <= node[2*i+1] + node[2*i+2];
      mix <= res.val[DW-1:0];
      sat <= res.ovf;
    end
  end

endmodule

// File: rtl/dsp_router_mixer.sv
// DSP routing/summing fabric: registered source routing, NOUT saturating mix channels
// and a small bus slice. Define DSP_ROUTER_SAT_CNT_EN for per-channel saturation counters.
module dsp_router_mixer
  import dsp_router_pkg::*;
#(
  parameter int DW      = 14,
  parameter int NSRC    = 16,
  parameter int LOG_SRC = 4,
  parameter int NDST    = 10,
  parameter int NDIR    = 10,
  parameter int LOG_DIR = 4,
  parameter int NOUT    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSRC*DW-1:0]   src_dat_i,
  output logic [NDST*DW-1:0]   dst_dat_o,
  input  logic [NDIR*DW-1:0]   dir_dat_i,
  output logic [NOUT*DW-1:0]   mix_dat_o,
  output logic [NOUT-1:0]      sat_o,
  input  logic [31:0]          sys_addr,
  input  logic [31:0]          sys_wdata,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [31:0]          sys_rdata,
  output logic                 sys_ack,
  output logic                 sys_err
);

  logic [LOG_SRC-1:0] slot;
  logic [15:0]        off;
  sel_t               in_sel  [NDST];
  sel_t               out_sel [NDST];
  sel_t               insel_rd;
  sel_t               outsel_rd;
  logic [NOUT-1:0]    sticky;
  logic [DW-1:0]      src_arr [NSRC];
  logic               is_local;
  logic               slot_ok;
  logic               access;
  logic               sticky_cor;
  logic [15:0]        cnt_rd;
  logic [31:0]        rd_val;
  logic               unused_bus;

  assign slot       = sys_addr[16 +: LOG_SRC];
  assign off        = sys_addr[15:0];
  assign unused_bus = ^{sys_addr[31:16+LOG_SRC], sys_wdata};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign src_arr[s] = src_dat_i[s*DW +: DW];
  end

  // Routing stage: selects past the last source deliver silence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst_dat_o <= '0;
    end else begin
      for (int d = 0; d < NDST; d++) begin
        if (in_sel[d] < sel_t'(NSRC)) dst_dat_o[d*DW +: DW] <= src_arr[in_sel[d][LOG_SRC-1:0]];
        else                          dst_dat_o[d*DW +: DW] <= '0;
      end
    end
  end

  for (genvar o = 0; o < NOUT; o++) begin : g_mix
    logic [NDIR-1:0] en;
    always_comb begin
      en = '0;
      for (int k = 0; k < NDIR; k++) en[k] = out_sel[k][o];
    end
    dsp_adder_tree #(.DW(DW), .NDIR(NDIR), .LOG_DIR(LOG_DIR)) u_tree (
      .clk (clk_i),
      .rst (rst_i),
      .dir (dir_dat_i),
      .en  (en),
      .mix (mix_dat_o[o*DW +: DW]),
      .sat (sat_o[o])
    );
  end

  always_comb begin
    is_local   = (off == OFF_INSEL) || (off == OFF_OUTSEL) ||
                 (off == OFF_STICKY) || (off == OFF_LIVESAT);
    slot_ok    = (32'(slot) < 32'(NDST));
    access     = (sys_wen | sys_ren) & is_local;
    sticky_cor = sys_ren & (off == OFF_STICKY) & (slot == '0);
    insel_rd   = '0;
    outsel_rd  = '0;
    for (int s = 0; s < NDST; s++) begin
      if (32'(slot) == 32'(s)) begin
        insel_rd  = in_sel[s];
        outsel_rd = out_sel[s];
      end else begin
        insel_rd  = insel_rd;
        outsel_rd = outsel_rd;
      end
    end
  end

`ifdef DSP_ROUTER_SAT_CNT_EN
  logic [15:0]     sat_cnt [NOUT];
  logic [NOUT-1:0] cnt_cor;

  always_comb begin
    cnt_rd  = 16'd0;
    cnt_cor = '0;
    for (int o = 0; o < NOUT; o++) begin
      if (32'(slot) == 32'(o + 1)) begin
        cnt_rd     = sat_cnt[o];
        cnt_cor[o] = sys_ren & (off == OFF_STICKY) & slot_ok;
      end else begin
        cnt_rd = cnt_rd;
      end
    end
  end

  // A clear-on-read restarts from the current cycle, so a colliding event leaves 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int o = 0; o < NOUT; o++) sat_cnt[o] <= 16'd0;
    end else begin
      for (int o = 0; o < NOUT; o++) begin
        if (cnt_cor[o])                                sat_cnt[o] <= {15'd0, sat_o[o]};
        else if (sat_o[o] && (sat_cnt[o] != 16'hFFFF)) sat_cnt[o] <= sat_cnt[o] + 16'd1;
        else                                           sat_cnt[o] <= sat_cnt[o];
      end
    end
  end
`else
  assign cnt_rd = 16'd0;
`endif

  always_comb begin
    rd_val = 32'd0;
    if (slot_ok) begin
      case (off)
        OFF_INSEL:   rd_val = {{(32-SEL_W){1'b0}}, insel_rd};
        OFF_OUTSEL:  rd_val = {{(32-SEL_W){1'b0}}, outsel_rd};
        OFF_STICKY:  rd_val = (slot == '0) ? {{(32-NOUT){1'b0}}, sticky} : {16'd0, cnt_rd};
        OFF_LIVESAT: rd_val = (slot == '0) ? {{(32-NOUT){1'b0}}, sat_o} : 32'd0;
        default:     rd_val = 32'd0;
      endcase
    end else begin
      rd_val = 32'd0;
    end
  end

  // Bus handshake and select registers; out-of-range slots ack with an error and no write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= 32'd0;
      for (int s = 0; s < NDST; s++) begin
        in_sel[s]  <= '0;
        out_sel[s] <= '0;
      end
    end else begin
      sys_ack   <= access;
      sys_err   <= access & ~slot_ok;
      sys_rdata <= access ? rd_val : sys_rdata;
      for (int s = 0; s < NDST; s++) begin
        if (access && sys_wen && (32'(slot) == 32'(s))) begin
          case (off)
            OFF_INSEL:  in_sel[s]  <= sel_t'(sys_wdata[LOG_SRC-1:0]);
            OFF_OUTSEL: out_sel[s] <= sel_t'(sys_wdata[NOUT-1:0]);
            default:    in_sel[s]  <= in_sel[s];
          endcase
        end
      end
    end
  end

  // Sticky flags: a clearing read still captures a saturation seen in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sticky <= '0;
    else       sticky <= (sticky_cor ? '0 : sticky) | sat_o;
  end

endmodule

// File: tb/tb_dsp_router_mixer.sv
// Self-checking bench for dsp_router_mixer: directed bus/routing/saturation steps plus
// randomized mix bursts compared against an arithmetic reference model.
module tb_dsp_router_mixer;

  localparam int DW = 14, NSRC = 12, LOG_SRC = 4, NDST = 10, NDIR = 10, LOG_DIR = 4, NOUT = 2;
  localparam int LAT = LOG_DIR + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NSRC*DW-1:0]  src_dat;
  logic [NDST*DW-1:0]  dst_dat;
  logic [NDIR*DW-1:0]  dir_dat;
  logic [NOUT*DW-1:0]  mix_dat;
  logic [NOUT-1:0]     sat;
  logic [31:0]         sys_addr = 32'd0;
  logic [31:0]         sys_wdata = 32'd0;
  logic                sys_wen = 1'b0;
  logic                sys_ren = 1'b0;
  logic [31:0]         sys_rdata;
  logic                sys_ack;
  logic                sys_err;

  logic [DW-1:0]   src [NSRC];
  logic [DW-1:0]   dir [NDIR];
  logic [NOUT-1:0] osel_m [NDIR];
  logic [DW-1:0]   exp_m [64][NOUT];
  logic            exp_s [64][NOUT];
  logic [31:0]     rd;
  logic            ak, er;
  int              tests = 0;
  int              fails = 0;

  dsp_router_mixer #(.DW(DW), .NSRC(NSRC), .LOG_SRC(LOG_SRC), .NDST(NDST),
                     .NDIR(NDIR), .LOG_DIR(LOG_DIR), .NOUT(NOUT)) dut (
    .clk_i(clk), .rst_i(rst), .src_dat_i(src_dat), .dst_dat_o(dst_dat),
    .dir_dat_i(dir_dat), .mix_dat_o(mix_dat), .sat_o(sat),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_dat = '0;
    dir_dat = '0;
    for (int s = 0; s < NSRC; s++) src_dat[s*DW +: DW] = src[s];
    for (int k = 0; k < NDIR; k++) dir_dat[k*DW +: DW] = dir[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ad(input int slot, input int off);
    return (32'(slot) << 16) | 32'(off);
  endfunction

  task automatic bus_rd(input logic [31:0] a);
    sys_addr = a;
    sys_ren  = 1'b1;
    tick();
    sys_ren = 1'b0;
    rd = sys_rdata;
    ak = sys_ack;
    er = sys_err;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] w);
    sys_addr  = a;
    sys_wdata = w;
    sys_wen   = 1'b1;
    tick();
    sys_wen = 1'b0;
    ak = sys_ack;
    er = sys_err;
  endtask

  function automatic logic [DW-1:0] mix_of(input int o);
    return mix_dat[o*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] route_model(input int sel);
    return (sel < NSRC) ? src[sel] : '0;
  endfunction

  // Reference mix: integer sum of the selected contributors, clamped to the sample range.
  task automatic model_mix(input int idx);
    for (int o = 0; o < NOUT; o++) begin
      int sum = 0;
      for (int k = 0; k < NDIR; k++) if (osel_m[k][o]) sum += int'($signed(dir[k]));
      if (sum > (1 << (DW-1)) - 1) begin
        exp_m[idx][o] = DW'((1 << (DW-1)) - 1); exp_s[idx][o] = 1'b1;
      end else if (sum < -(1 << (DW-1))) begin
        exp_m[idx][o] = DW'(-(1 << (DW-1)));    exp_s[idx][o] = 1'b1;
      end else begin
        exp_m[idx][o] = DW'(sum);               exp_s[idx][o] = 1'b0;
      end
    end
  endtask

  task automatic run_burst(input int n);
    for (int k = 0; k < NDIR; k++) begin
      osel_m[k] = NOUT'($urandom_range(0, 3));
      bus_wr(ad(k, 4), 32'(osel_m[k]));
    end
    for (int i = 0; i < n + LAT; i++) begin
      if (i >= LAT) begin
        for (int o = 0; o < NOUT; o++) begin
          chk($sformatf("burst_mix%0d_%0d", o, i - LAT), 32'(mix_of(o)), 32'(exp_m[i-LAT][o]));
          chk($sformatf("burst_sat%0d_%0d", o, i - LAT), 32'(sat[o]), 32'(exp_s[i-LAT][o]));
        end
      end
      for (int k = 0; k < NDIR; k++) begin
        if (i >= n) dir[k] = '0;
        else begin
          case ($urandom_range(0, 3))
            0:       dir[k] = DW'($urandom);
            1:       dir[k] = 14'h1FFF;
            2:       dir[k] = 14'h2000;
            default: dir[k] = DW'(int'($urandom_range(0, 600)) - 300);
          endcase
        end
      end
      if (i < n) model_mix(i);
      tick();
    end
  endtask

  initial begin
    for (int s = 0; s < NSRC; s++) src[s] = '0;
    for (int k = 0; k < NDIR; k++) dir[k] = '0;
    for (int k = 0; k < NDIR; k++) osel_m[k] = '0;
    repeat (2) tick();
    chk("rst_dst", 32'(|dst_dat), 32'd0);
    chk("rst_mix", 32'(|mix_dat), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_ack", 32'(sys_ack), 32'd0);
    chk("rst_err", 32'(sys_err), 32'd0);
    chk("rst_rdata", sys_rdata, 32'd0);
    rst = 1'b0;
    tick();
    bus_rd(ad(3, 0));
    chk("rst_insel3", rd, 32'd0);
    chk("rd_ack", 32'(ak), 32'd1);
    tick();
    chk("ack_pulse", 32'(sys_ack), 32'd0);

    // Directed routing
    src[5] = 14'h0123;
    bus_wr(ad(3, 0), 32'd5);
    chk("wr_ack", 32'(ak), 32'd1);
    tick();
    chk("route_3_5", 32'(dst_dat[3*DW +: DW]), 32'h0123);
    bus_wr(ad(3, 0), 32'd15);
    tick();
    chk("route_3_15", 32'(dst_dat[3*DW +: DW]), 32'd0);

    // Randomized routing against the selection rule
    for (int r = 0; r < 24; r++) begin
      int d, sl;
      d  = $urandom_range(0, NDST - 1);
      sl = $urandom_range(0, 15);
      bus_wr(ad(d, 0), 32'(sl) | 32'hFFF0);
      for (int s = 0; s < NSRC; s++) src[s] = DW'($urandom);
      tick();
      chk($sformatf("route_rand_%0d", r), 32'(dst_dat[d*DW +: DW]), 32'(route_model(sl)));
      bus_rd(ad(d, 0));
      chk($sformatf("insel_rb_%0d", r), rd, 32'(sl));
    end

    // Directed mix with exact latency
    bus_wr(ad(0, 4), 32'd1);
    bus_wr(ad(1, 4), 32'd3);
    bus_rd(ad(1, 4));
    chk("outsel_rb", rd, 32'd3);
    repeat (LAT + 1) tick();
    dir[0] = 14'd1000;
    dir[1] = DW'(-300);
    repeat (LAT - 1) tick();
    chk("mix_early", 32'(mix_of(0)), 32'd0);
    tick();
    chk("mix0_700", 32'(mix_of(0)), 32'(14'd700));
    chk("mix1_m300", 32'(mix_of(1)), 32'(14'h3ED4));
    chk("mix_nosat", 32'(sat), 32'd0);

    // Positive saturation, sticky set, clear-on-read
    bus_wr(ad(1, 4), 32'd1);
    bus_wr(ad(2, 4), 32'd1);
    dir[0] = 14'h1FFF; dir[1] = 14'h1FFF; dir[2] = 14'h1FFF;
    repeat (LAT) tick();
    chk("sat_mix0", 32'(mix_of(0)), 32'h1FFF);
    chk("sat_flag", 32'(sat), 32'd1);
    for (int k = 0; k < NDIR; k++) dir[k] = '0;
    repeat (LAT + 2) tick();
    chk("sat_gone", 32'(sat), 32'd0);
    bus_rd(ad(0, 8));
    chk("sticky_rd1", rd, 32'd1);
    bus_rd(ad(0, 8));
    chk("sticky_rd2", rd, 32'd0);

    // Negative saturation held: collision keeps the flag
    dir[0] = 14'h2000; dir[1] = 14'h2000; dir[2] = 14'h2000;
    repeat (LAT) tick();
    chk("nsat_mix0", 32'(mix_of(0)), 32'h2000);
    repeat (2) tick();
    bus_rd(ad(0, 8));
    chk("collide_rd1", rd, 32'd1);
    bus_rd(ad(0, 8));
    chk("collide_rd2", rd, 32'd1);
    bus_rd(ad(0, 12));
    chk("livesat", rd, 32'd1);
    bus_rd(ad(1, 8));
    chk("cnt_ack", 32'(ak), 32'd1);
`ifndef DSP_ROUTER_SAT_CNT_EN
    chk("cnt_absent", rd, 32'd0);
`endif

    // Bus decode: non-local offset, out-of-range slot, ignored writes
    bus_wr(ad(3, 0), 32'd9);
    bus_rd(ad(3, 0));
    chk("insel3_9", rd, 32'd9);
    bus_rd(ad(0, 32'h20));
    chk("nonlocal_ack", 32'(ak), 32'd0);
    chk("nonlocal_hold", rd, 32'd9);
    bus_rd(ad(12, 0));
    chk("err_ack", 32'(ak), 32'd1);
    chk("err_err", 32'(er), 32'd1);
    chk("err_rdata", rd, 32'd0);
    bus_wr(ad(0, 8), 32'hFFFF);
    chk("wr_sticky_ack", 32'(ak), 32'd1);
    chk("wr_sticky_noerr", 32'(er), 32'd0);
    bus_rd(ad(0, 4));
    chk("outsel0_kept", rd, 32'd1);

    // Randomized mix bursts
    for (int b = 0; b < 3; b++) run_burst(30);

    // Asynchronous reset mid-stream
    for (int s = 0; s < NSRC; s++) src[s] = 14'h1555;
    for (int k = 0; k < NDIR; k++) dir[k] = 14'h1FFF;
    bus_wr(ad(3, 0), 32'd4);
    bus_wr(ad(0, 4), 32'd3);
    repeat (LAT + 1) tick();
    chk("pre_rst_sat", 32'(sat), 32'd3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_dst", 32'(|dst_dat), 32'd0);
    chk("arst_mix", 32'(|mix_dat), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    chk("arst_ack", 32'(sys_ack), 32'd0);
    chk("arst_rdata", sys_rdata, 32'd0);
    tick();
    rst = 1'b0;
    bus_rd(ad(3, 0));
    chk("post_rst_insel", rd, 32'd0);
    bus_rd(ad(0, 4));
    chk("post_rst_outsel", rd, 32'd0);
    repeat (LAT + 1) tick();
    chk("post_rst_mix", 32'(|mix_dat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
